// File: rtl/jedro_1_defines_pkg.sv
// rtl/jedro_1_defines_pkg.sv - shared types for the jedro_1 store unit
package jedro_1_defines_pkg;

   typedef enum logic [1:0] {ST_BYTE, ST_HALF, ST_WORD, ST_ILLEGAL} store_width_e;

   typedef enum logic [1:0] {SBU_IDLE, SBU_WRITE, SBU_WAIT} sbu_state_e;

   localparam int unsigned SBU_LANES = 4;

endpackage

// File: rtl/jedro_1_sbu_align.sv
// rtl/jedro_1_sbu_align.sv - store lane alignment, byte enables and misalignment check
module jedro_1_sbu_align
   import jedro_1_defines_pkg::*;
(
   input  logic [1:0]  width_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  we_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o
);

   // Data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      we_o         = 4'b0000;
      wdata_o      = wdata_i;
      misaligned_o = 1'b0;
      case (store_width_e'(width_i))
         ST_BYTE: begin
            we_o    = 4'b0001 << offset_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         ST_HALF: begin
            we_o         = 4'b0011 << offset_i;
            wdata_o      = {2{wdata_i[15:0]}};
            misaligned_o = offset_i[0];
         end
         ST_WORD: begin
            we_o         = 4'b1111;
            misaligned_o = (offset_i != 2'b00);
         end
         default: begin
            misaligned_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/jedro_1_sbu.sv
// rtl/jedro_1_sbu.sv - jedro_1 store unit: request capture, write FSM and latency counter
module jedro_1_sbu
   import jedro_1_defines_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned WRITE_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  ctrl_valid_i,
   output logic                  ctrl_ready_o,
   input  logic [1:0]            ctrl_width_i,
   input  logic [ADDR_WIDTH-1:0] ctrl_addr_i,
   input  logic [DATA_WIDTH-1:0] ctrl_wdata_i,
   output logic                  mem_en_o,
   output logic [3:0]            mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  done_o,
   output logic                  misaligned_o,
   output logic [ADDR_WIDTH-1:0] misaligned_addr_o
);

   localparam int CNT_W = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

   sbu_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [3:0]            we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  mis_q, mis_d;
   logic [ADDR_WIDTH-1:0] mis_addr_q, mis_addr_d;

   logic                  ready;
   logic                  done;
   logic [3:0]            al_we;
   logic [31:0]           al_wdata;
   logic                  al_mis;

   jedro_1_sbu_align u_align (
      .width_i      (ctrl_width_i),
      .offset_i     (ctrl_addr_i[1:0]),
      .wdata_i      (ctrl_wdata_i),
      .we_o         (al_we),
      .wdata_o      (al_wdata),
      .misaligned_o (al_mis)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mis_d      = 1'b0;
      mis_addr_d = mis_addr_q;
      ready      = 1'b0;
      done       = 1'b0;
      case (state_q)
         SBU_IDLE: begin
            ready = 1'b1;
         end
         SBU_WRITE: begin
            state_d = SBU_WAIT;
            cnt_d   = CNT_W'(WRITE_LATENCY - 1);
         end
         SBU_WAIT: begin
            // The commit cycle also accepts the next request, so stores stream without a gap.
            if (cnt_q == '0) begin
               ready   = 1'b1;
               done    = 1'b1;
               state_d = SBU_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = SBU_IDLE;
         end
      endcase
      if (ready && ctrl_valid_i) begin
         if (al_mis) begin
            mis_d      = 1'b1;
            mis_addr_d = ctrl_addr_i;
         end else begin
            state_d = SBU_WRITE;
            we_d    = al_we;
            addr_d  = {ctrl_addr_i[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = al_wdata;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= SBU_IDLE;
         cnt_q      <= '0;
         we_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   assign ctrl_ready_o      = ready;
   assign done_o            = done;
   assign mem_en_o          = (state_q == SBU_WRITE);
   assign mem_we_o          = (state_q == SBU_WRITE) ? we_q : 4'b0000;
   assign mem_addr_o        = addr_q;
   assign mem_wdata_o       = wdata_q;
   assign misaligned_o      = mis_q;
   assign misaligned_addr_o = mis_addr_q;

endmodule
